am_demod_tdm_ctrl: RTL

AM_DEMOD_TDM_CTRL -- requirements
Module: am_demod_tdm_ctrl

---
 rtl/am_demod_pkg.sv | 22 ++
 rtl/am_sqrt_iter.sv | 76 +++++++
 rtl/am_demod_tdm_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/am_demod_pkg.sv
// Shared types and default sizing for the TDM AM demodulator slice.
// Optional rounding of the root is enabled by defining AM_DEMOD_SQRT_ROUND_EN.
package am_demod_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 12;
   localparam int unsigned SQRT_ITER      = DATA_WIDTH_DEF + 1;
   localparam int unsigned SUM_WIDTH      = 2 * DATA_WIDTH_DEF + 2;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_I,
      ISSUE_Q,
      WAIT,
      ACC,
      SQRT
   } state_t;

   function automatic int unsigned sum_width(input int unsigned dw);
      return 2 * dw + 2;
   endfunction

endpackage

// File: rtl/am_sqrt_iter.sv
// Non-restoring integer square root, one root bit per cycle (DATA_WIDTH+1 iterations).
// AM_DEMOD_SQRT_ROUND_EN folds round-to-nearest into the final iteration.
module am_sqrt_iter
   import am_demod_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2*DATA_WIDTH+1:0] radicand,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   root
);

   localparam int unsigned ITER = DATA_WIDTH + 1;
   localparam int unsigned SW   = sum_width(DATA_WIDTH);
   localparam int unsigned RW   = DATA_WIDTH + 6;
   localparam int unsigned IW   = $clog2(ITER + 1);

   logic                 busy;
   logic [IW-1:0]        iter;
   logic [SW-1:0]        rad_sh;
   logic signed [RW-1:0] rem;
   logic signed [RW-1:0] rem_sh;
   logic signed [RW-1:0] trial;
   logic signed [RW-1:0] rem_nx;
   logic [DATA_WIDTH-1:0] q;
   logic [DATA_WIDTH:0]   q_nx;
   logic [DATA_WIDTH-1:0] root_trunc;
`ifdef AM_DEMOD_SQRT_ROUND_EN
   logic signed [RW-1:0] rem_fin;
`endif

   assign done = busy && (iter == IW'(ITER - 1));

   // Subtract {q,01} while the remainder is non-negative, add {q,11} once it goes negative.
   always_comb begin
      rem_sh      = rem <<< 2;
      rem_sh[1:0] = rad_sh[SW-1 -: 2];
      trial       = RW'({q, rem[RW-1], 1'b1});
      rem_nx      = rem[RW-1] ? (rem_sh + trial) : (rem_sh - trial);
      q_nx        = {q, ~rem_nx[RW-1]};
      root_trunc  = q_nx[DATA_WIDTH-1:0];
      root        = root_trunc;
`ifdef AM_DEMOD_SQRT_ROUND_EN
      rem_fin = rem_nx[RW-1] ? (rem_nx + RW'({q_nx, 1'b1})) : rem_nx;
      if ((rem_fin > RW'(q_nx)) && (root_trunc != '1))
         root = root_trunc + DATA_WIDTH'(1);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         iter   <= '0;
         rad_sh <= '0;
         rem    <= '0;
         q      <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         iter   <= '0;
         rad_sh <= radicand;
         rem    <= '0;
         q      <= '0;
      end else if (busy) begin
         rad_sh <= rad_sh << 2;
         rem    <= rem_nx;
         q      <= q_nx[DATA_WIDTH-1:0];
         iter   <= iter + IW'(1);
         if (done)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/am_demod_tdm_ctrl.sv
// AM magnitude sqrt(I^2+Q^2) using one time-shared external multiplier and an iterative root.
// AM_DEMOD_SQRT_ROUND_EN selects a rounded instead of truncated root (latency unchanged).
module am_demod_tdm_ctrl
   import am_demod_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned MULT_LATENCY = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [DATA_WIDTH-1:0]   inphase,
   input  logic signed [DATA_WIDTH-1:0]   quadrature,
   output logic                           mult_en,
   output logic signed [DATA_WIDTH-1:0]   mult_a,
   output logic signed [DATA_WIDTH-1:0]   mult_b,
   input  logic signed [2*DATA_WIDTH-1:0] mult_result,
   output logic                           out_valid,
   output logic [DATA_WIDTH-1:0]          amdemod_out
);

   localparam int unsigned SW = sum_width(DATA_WIDTH);
   localparam int unsigned CW = $clog2(MULT_LATENCY + 3);
   localparam logic [CW-1:0] I_SQ_AT = CW'(MULT_LATENCY);
   localparam logic [CW-1:0] Q_SQ_AT = CW'(MULT_LATENCY + 1);

   state_t state, state_nx;

   logic [CW-1:0]                cnt;
   logic signed [DATA_WIDTH-1:0] i_cap;
   logic signed [DATA_WIDTH-1:0] q_cap;
   logic [2*DATA_WIDTH-1:0]      i_sq;
   logic [SW-1:0]                square_sum;
   logic                         sqrt_start;
   logic                         sqrt_done;
   logic [DATA_WIDTH-1:0]        sqrt_root;

   assign in_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      mult_en    = 1'b0;
      mult_a     = '0;
      mult_b     = '0;
      sqrt_start = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid)
               state_nx = ISSUE_I;
         end
         ISSUE_I: begin
            mult_en  = 1'b1;
            mult_a   = i_cap;
            mult_b   = i_cap;
            state_nx = ISSUE_Q;
         end
         ISSUE_Q: begin
            mult_en  = 1'b1;
            mult_a   = q_cap;
            mult_b   = q_cap;
            state_nx = WAIT;
         end
         WAIT: begin
            mult_en = 1'b1;
            if (cnt == Q_SQ_AT)
               state_nx = ACC;
         end
         ACC: begin
            sqrt_start = 1'b1;
            state_nx   = SQRT;
         end
         SQRT: begin
            if (sqrt_done)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // cnt counts cycles since ISSUE_I, so each square is caught MULT_LATENCY cycles after its issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         i_cap       <= '0;
         q_cap       <= '0;
         i_sq        <= '0;
         square_sum  <= '0;
         out_valid   <= 1'b0;
         amdemod_out <= '0;
      end else begin
         out_valid <= 1'b0;
         if ((state == IDLE) && in_valid) begin
            i_cap <= inphase;
            q_cap <= quadrature;
            cnt   <= '0;
         end else if (mult_en) begin
            cnt <= cnt + CW'(1);
         end
         if (mult_en && (cnt == I_SQ_AT))
            i_sq <= $unsigned(mult_result);
         if (mult_en && (cnt == Q_SQ_AT))
            square_sum <= SW'(i_sq) + SW'($unsigned(mult_result));
         if ((state == SQRT) && sqrt_done) begin
            out_valid   <= 1'b1;
            amdemod_out <= sqrt_root;
         end
      end
   end

   am_sqrt_iter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sqrt (
      .clk      (clk),
      .rst      (rst),
      .start    (sqrt_start),
      .radicand (square_sum),
      .done     (sqrt_done),
      .root     (sqrt_root)
   );

endmodule
